// File: rtl/pad_tuser_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// pad_tuser_sequencer_pkg
// Shared definitions for the TUSER sequencer and its consumers:
//   - default field widths (BITS_*_DEF) used as parameter defaults
//   - TUSER bit indices (I_*) understood by the padding filter/accumulators
//   - sequencer state encoding
// ---------------------------------------------------------------------------
package pad_tuser_sequencer_pkg;

   localparam int KW_MAX_DEF      = 7;
   localparam int BITS_KW2_DEF    = 2;
   localparam int BITS_COLS_DEF   = 8;
   localparam int BITS_CIN_DEF    = 10;
   localparam int BITS_BLOCKS_DEF = 10;
   localparam int DATA_WIDTH_DEF  = 64;
   localparam int TUSER_WIDTH_DEF = 8;

   // TUSER layout: kw2 occupies [I_KW2 +: BITS_KW2], flags sit above it.
   localparam int I_KW2          = 0;
   localparam int I_IS_CONFIG    = 2;
   localparam int I_IS_CIN_LAST  = 3;
   localparam int I_IS_COLS_1_K2 = 4;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_CONFIG = 2'd1,
      ST_STREAM = 2'd2
   } state_t;

endpackage

// File: rtl/pad_tuser_sequencer_wrap_counter.sv
// ---------------------------------------------------------------------------
// pad_tuser_sequencer_wrap_counter
// Position counter that advances on en and returns to 0 after max_val.
// Ports:
//   clk, srst   clock, synchronous active-high reset
//   clr         synchronous clear (start of a new layer)
//   en          advance by one (or wrap) this cycle
//   max_val     terminal count
//   count       current position
//   wrap        count is at its terminal value; the next en wraps it, so
//               chaining this into the next counter's en gives carry
// ---------------------------------------------------------------------------
module pad_tuser_sequencer_wrap_counter #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             srst,
   input  logic             clr,
   input  logic             en,
   input  logic [WIDTH-1:0] max_val,
   output logic [WIDTH-1:0] count,
   output logic             wrap
);

   logic [WIDTH-1:0] count_reg;

   assign count = count_reg;
   assign wrap  = (count_reg == max_val);

   always_ff @(posedge clk) begin
      if (srst || clr) begin
         count_reg <= '0;
      end else if (en) begin
         count_reg <= wrap ? '0 : count_reg + WIDTH'(1);
      end
   end

endmodule

// File: rtl/pad_tuser_sequencer.sv
// ---------------------------------------------------------------------------
// pad_tuser_sequencer
// Tags the input pixel stream with per-beat TUSER control for the padding
// filter and accumulators. One layer config is accepted, one config beat is
// emitted, then every data beat carries cin/column position flags until the
// last beat of the layer.
// Ports:
//   aclk, areset            clock, synchronous active-high reset
//   cfg_valid/cfg_ready     layer config handshake (ready only in IDLE)
//   cfg_kw2, cfg_cols_1,
//   cfg_cin_1, cfg_blocks_1 kernel half-width and (count - 1) dimensions
//   s_valid/s_ready/s_data  input pixel stream
//   m_valid/m_ready         output stream handshake
//   m_data/m_user/m_last    registered output beat, tuser and end-of-layer
//   busy                    sequencer active or output still pending
// ---------------------------------------------------------------------------
module pad_tuser_sequencer
   import pad_tuser_sequencer_pkg::*;
#(
   parameter int KW_MAX      = KW_MAX_DEF,
   parameter int BITS_KW2    = BITS_KW2_DEF,
   parameter int BITS_COLS   = BITS_COLS_DEF,
   parameter int BITS_CIN    = BITS_CIN_DEF,
   parameter int BITS_BLOCKS = BITS_BLOCKS_DEF,
   parameter int DATA_WIDTH  = DATA_WIDTH_DEF,
   parameter int TUSER_WIDTH = TUSER_WIDTH_DEF
) (
   input  logic                   aclk,
   input  logic                   areset,
   input  logic                   cfg_valid,
   output logic                   cfg_ready,
   input  logic [BITS_KW2-1:0]    cfg_kw2,
   input  logic [BITS_COLS-1:0]   cfg_cols_1,
   input  logic [BITS_CIN-1:0]    cfg_cin_1,
   input  logic [BITS_BLOCKS-1:0] cfg_blocks_1,
   input  logic                   s_valid,
   output logic                   s_ready,
   input  logic [DATA_WIDTH-1:0]  s_data,
   output logic                   m_valid,
   input  logic                   m_ready,
   output logic [DATA_WIDTH-1:0]  m_data,
   output logic [TUSER_WIDTH-1:0] m_user,
   output logic                   m_last,
   output logic                   busy
);

   localparam int CMP_W = BITS_COLS + 1;
   // Half-widths beyond the largest supported kernel are clamped.
   localparam logic [BITS_KW2-1:0] KW2_MAX = BITS_KW2'(KW_MAX / 2);

   state_t state_reg, state_next;

   logic [BITS_KW2-1:0]    kw2_reg;
   logic [BITS_COLS-1:0]   cols_1_reg;
   logic [BITS_CIN-1:0]    cin_1_reg;
   logic [BITS_BLOCKS-1:0] blocks_1_reg;

   logic                   m_valid_reg;
   logic [DATA_WIDTH-1:0]  m_data_reg;
   logic [TUSER_WIDTH-1:0] m_user_reg;
   logic                   m_last_reg;

   logic [BITS_CIN-1:0]    cin_cnt;
   logic [BITS_COLS-1:0]   col_cnt;
   // Only the block counter's terminal flag matters downstream.
   logic [BITS_BLOCKS-1:0] blk_cnt_unused;
   logic                   cin_wrap, col_wrap, blk_wrap;

   logic                   out_free, cfg_take, cfg_load, beat_take, layer_end;
   logic [CMP_W-1:0]       col_target;
   logic                   near_end;
   logic [TUSER_WIDTH-1:0] beat_user, cfg_user;

   assign out_free  = !m_valid_reg || m_ready;
   assign layer_end = cin_wrap && col_wrap && blk_wrap;

   // One bit wider than the column count so cols_1 < kw2 underflows into
   // the top bit and can never match col_cnt.
   assign col_target = {1'b0, cols_1_reg} - CMP_W'(kw2_reg);
   assign near_end   = (kw2_reg != '0) && ({1'b0, col_cnt} == col_target);

   always_comb begin
      beat_user = '0;
      beat_user[I_KW2 +: BITS_KW2] = kw2_reg;
      beat_user[I_IS_CIN_LAST]     = cin_wrap;
      beat_user[I_IS_COLS_1_K2]    = near_end;
      cfg_user = '0;
      cfg_user[I_KW2 +: BITS_KW2]  = kw2_reg;
      cfg_user[I_IS_CONFIG]        = 1'b1;
   end

   always_comb begin
      state_next = state_reg;
      cfg_ready  = 1'b0;
      s_ready    = 1'b0;
      cfg_take   = 1'b0;
      cfg_load   = 1'b0;
      beat_take  = 1'b0;
      case (state_reg)
         ST_IDLE: begin
            cfg_ready = 1'b1;
            if (cfg_valid) begin
               cfg_take   = 1'b1;
               state_next = ST_CONFIG;
            end
         end
         ST_CONFIG: begin
            // Waits here while a previous layer's last beat is still pending.
            if (out_free) begin
               cfg_load   = 1'b1;
               state_next = ST_STREAM;
            end
         end
         ST_STREAM: begin
            s_ready = out_free;
            if (s_valid && out_free) begin
               beat_take = 1'b1;
               if (layer_end) begin
                  state_next = ST_IDLE;
               end
            end
         end
         default: state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge aclk) begin
      if (areset) begin
         state_reg    <= ST_IDLE;
         kw2_reg      <= '0;
         cols_1_reg   <= '0;
         cin_1_reg    <= '0;
         blocks_1_reg <= '0;
         m_valid_reg  <= 1'b0;
         m_data_reg   <= '0;
         m_user_reg   <= '0;
         m_last_reg   <= 1'b0;
      end else begin
         state_reg <= state_next;
         if (cfg_take) begin
            kw2_reg      <= (cfg_kw2 > KW2_MAX) ? KW2_MAX : cfg_kw2;
            cols_1_reg   <= cfg_cols_1;
            cin_1_reg    <= cfg_cin_1;
            blocks_1_reg <= cfg_blocks_1;
         end
         if (cfg_load) begin
            m_valid_reg <= 1'b1;
            m_data_reg  <= '0;
            m_user_reg  <= cfg_user;
            m_last_reg  <= 1'b0;
         end else if (beat_take) begin
            m_valid_reg <= 1'b1;
            m_data_reg  <= s_data;
            m_user_reg  <= beat_user;
            m_last_reg  <= layer_end;
         end else if (m_ready) begin
            m_valid_reg <= 1'b0;
         end
      end
   end

   // cin is innermost; each counter advances when all inner ones wrap.
   pad_tuser_sequencer_wrap_counter #(.WIDTH(BITS_CIN)) u_cin_cnt (
      .clk     (aclk),
      .srst    (areset),
      .clr     (cfg_take),
      .en      (beat_take),
      .max_val (cin_1_reg),
      .count   (cin_cnt),
      .wrap    (cin_wrap)
   );

   pad_tuser_sequencer_wrap_counter #(.WIDTH(BITS_COLS)) u_col_cnt (
      .clk     (aclk),
      .srst    (areset),
      .clr     (cfg_take),
      .en      (beat_take && cin_wrap),
      .max_val (cols_1_reg),
      .count   (col_cnt),
      .wrap    (col_wrap)
   );

   pad_tuser_sequencer_wrap_counter #(.WIDTH(BITS_BLOCKS)) u_blk_cnt (
      .clk     (aclk),
      .srst    (areset),
      .clr     (cfg_take),
      .en      (beat_take && cin_wrap && col_wrap),
      .max_val (blocks_1_reg),
      .count   (blk_cnt_unused),
      .wrap    (blk_wrap)
   );

   assign m_valid = m_valid_reg;
   assign m_data  = m_data_reg;
   assign m_user  = m_user_reg;
   assign m_last  = m_last_reg;
   assign busy    = (state_reg != ST_IDLE) || m_valid_reg;

endmodule

// File: tb/tb_pad_tuser_sequencer.sv
module tb_pad_tuser_sequencer;
   import pad_tuser_sequencer_pkg::*;

   logic        aclk = 1'b0;
   logic        areset = 1'b1;
   logic        cfg_valid = 1'b0;
   logic        cfg_ready;
   logic [1:0]  cfg_kw2 = '0;
   logic [7:0]  cfg_cols_1 = '0;
   logic [9:0]  cfg_cin_1 = '0;
   logic [9:0]  cfg_blocks_1 = '0;
   logic        s_valid = 1'b0;
   logic        s_ready;
   logic [63:0] s_data = '0;
   logic        m_valid;
   logic        m_ready = 1'b0;
   logic [63:0] m_data;
   logic [7:0]  m_user;
   logic        m_last;
   logic        busy;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference beat stream for the current layer
   logic [63:0] exp_data[$];
   logic [7:0]  exp_user[$];
   logic        exp_last[$];
   logic [63:0] src[$];

   always #5 aclk = ~aclk;

   pad_tuser_sequencer dut (
      .aclk         (aclk),
      .areset       (areset),
      .cfg_valid    (cfg_valid),
      .cfg_ready    (cfg_ready),
      .cfg_kw2      (cfg_kw2),
      .cfg_cols_1   (cfg_cols_1),
      .cfg_cin_1    (cfg_cin_1),
      .cfg_blocks_1 (cfg_blocks_1),
      .s_valid      (s_valid),
      .s_ready      (s_ready),
      .s_data       (s_data),
      .m_valid      (m_valid),
      .m_ready      (m_ready),
      .m_data       (m_data),
      .m_user       (m_user),
      .m_last       (m_last),
      .busy         (busy)
   );

   function automatic logic [7:0] cfg_beat_user(input int kw2);
      return 8'((kw2 << I_KW2) | (1 << I_IS_CONFIG));
   endfunction

   // Layer model: nested position loops, flags from the layer rules.
   task automatic build_model(input int kw2, input int cols_1, input int cin_1, input int blocks_1);
      int u;
      logic [63:0] d;
      exp_data.delete(); exp_user.delete(); exp_last.delete(); src.delete();
      exp_data.push_back(64'd0);
      exp_user.push_back(cfg_beat_user(kw2));
      exp_last.push_back(1'b0);
      for (int b = 0; b <= blocks_1; b++)
         for (int col = 0; col <= cols_1; col++)
            for (int c = 0; c <= cin_1; c++) begin
               d = {$urandom, $urandom};
               src.push_back(d);
               exp_data.push_back(d);
               u = kw2 << I_KW2;
               if (c == cin_1) u |= 1 << I_IS_CIN_LAST;
               if (kw2 != 0 && cols_1 >= kw2 && col == cols_1 - kw2) u |= 1 << I_IS_COLS_1_K2;
               exp_user.push_back(8'(u));
               exp_last.push_back(b == blocks_1 && col == cols_1 && c == cin_1);
            end
   endtask

   // Runs one layer with random source gaps / sink stalls; stop_after >= 0
   // abandons the layer after that many output beats.
   task automatic run_layer(input string name, input int kw2, input int cols_1, input int cin_1,
                            input int blocks_1, input int ready_pct, input int src_pct,
                            input int stop_after, output int near_seen, output int cycles_used);
      int n_got, idx_src, n_exp;
      bit cfg_acc, s_acc, prev_stall;
      logic [63:0] p_data;
      logic [7:0]  p_user;
      logic        p_last;
      build_model(kw2, cols_1, cin_1, blocks_1);
      n_exp = exp_data.size();
      n_got = 0; idx_src = 0; cfg_acc = 0; s_acc = 0; prev_stall = 0;
      near_seen = 0; cycles_used = 0;
      p_data = '0; p_user = '0; p_last = 1'b0;
      cfg_kw2 = 2'(kw2); cfg_cols_1 = 8'(cols_1); cfg_cin_1 = 10'(cin_1); cfg_blocks_1 = 10'(blocks_1);
      for (int cyc = 0; cyc < 3000 && n_got < n_exp; cyc++) begin
         @(negedge aclk);
         cfg_valid = !cfg_acc;
         if (s_acc) begin s_valid = 1'b0; s_acc = 0; end
         if (!s_valid && idx_src < src.size() && $urandom_range(0, 99) < src_pct) begin
            s_valid = 1'b1;
            s_data  = src[idx_src];
         end
         m_ready = ($urandom_range(0, 99) < ready_pct);
         #1;
         if (prev_stall) begin
            n_checks++;
            if (m_valid !== 1'b1 || m_data !== p_data || m_user !== p_user || m_last !== p_last) begin
               n_fail++;
               $display("FAIL %s stall_hold beat %0d: got v=%b d=%h u=%h l=%b want v=1 d=%h u=%h l=%b",
                        name, n_got, m_valid, m_data, m_user, m_last, p_data, p_user, p_last);
            end
         end
         if (m_valid && m_ready) begin
            n_checks++;
            if (m_data !== exp_data[n_got] || m_user !== exp_user[n_got] || m_last !== exp_last[n_got]) begin
               n_fail++;
               $display("FAIL %s beat %0d: got d=%h u=%h l=%b want d=%h u=%h l=%b", name, n_got,
                        m_data, m_user, m_last, exp_data[n_got], exp_user[n_got], exp_last[n_got]);
            end else begin
               $display("beat %s #%0d ok u=%h l=%b", name, n_got, m_user, m_last);
            end
            if (m_user[I_IS_COLS_1_K2]) near_seen++;
            n_got++;
            if (n_got == n_exp) cycles_used = cyc + 1;
         end
         prev_stall = m_valid && !m_ready;
         p_data = m_data; p_user = m_user; p_last = m_last;
         if (cfg_valid && cfg_ready) cfg_acc = 1;
         if (s_valid && s_ready) begin s_acc = 1; idx_src++; end
         if (stop_after >= 0 && n_got >= stop_after) break;
      end
      @(negedge aclk);
      cfg_valid = 1'b0;
      s_valid   = 1'b0;
      m_ready   = 1'b1;
      if (stop_after < 0) begin
         n_checks++;
         if (n_got != n_exp) begin
            n_fail++;
            $display("FAIL %s beat_count: got %0d want %0d (timeout)", name, n_got, n_exp);
         end
         #1;
         n_checks++;
         if (m_valid !== 1'b0 || busy !== 1'b0 || cfg_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL %s idle_after: got v=%b busy=%b cfg_ready=%b want 0 0 1",
                     name, m_valid, busy, cfg_ready);
         end
      end
   endtask

   task automatic test_reset();
      areset = 1'b1;
      repeat (3) @(posedge aclk);
      @(negedge aclk);
      n_checks++;
      if (m_valid !== 1'b0 || m_data !== 64'd0 || m_user !== 8'd0 || m_last !== 1'b0 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_outputs: got v=%b d=%h u=%h l=%b busy=%b want all 0",
                  m_valid, m_data, m_user, m_last, busy);
      end
      areset = 1'b0;
      @(negedge aclk);
      n_checks++;
      if (cfg_ready !== 1'b1 || s_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_ready: got cfg_ready=%b s_ready=%b want 1 0", cfg_ready, s_ready);
      end
      $display("reset checked");
   endtask

   task automatic test_basic_layer();
      int near, cyc;
      run_layer("basic", 2, 7, 1, 0, 100, 100, -1, near, cyc);
      n_checks++;
      if (near != 2) begin
         n_fail++;
         $display("FAIL basic near_end_count: got %0d want 2", near);
      end
      n_checks++;
      if (cyc != 19) begin
         n_fail++;
         $display("FAIL basic throughput_cycles: got %0d want 19", cyc);
      end
   endtask

   task automatic test_backpressure();
      int near, cyc;
      run_layer("backpressure", 2, 7, 1, 0, 50, 80, -1, near, cyc);
      n_checks++;
      if (near != 2) begin
         n_fail++;
         $display("FAIL backpressure near_end_count: got %0d want 2", near);
      end
   endtask

   task automatic test_kw2_zero();
      int near, cyc;
      run_layer("kw2_zero", 0, 3, 0, 1, 70, 90, -1, near, cyc);
      n_checks++;
      if (near != 0) begin
         n_fail++;
         $display("FAIL kw2_zero near_end_count: got %0d want 0", near);
      end
   endtask

   // cols_1 (0) < kw2 (1) is an illegal config: no near-end flag at all.
   task automatic test_single_beat();
      int near, cyc;
      run_layer("single", 1, 0, 0, 0, 100, 100, -1, near, cyc);
      n_checks++;
      if (near != 0) begin
         n_fail++;
         $display("FAIL single near_end_count: got %0d want 0", near);
      end
   endtask

   task automatic test_back_to_back();
      logic [63:0] d1, d2;
      logic [7:0]  u1, u2;
      d1 = {$urandom, $urandom};
      d2 = {$urandom, $urandom};
      u1 = 8'((1 << I_KW2) | (1 << I_IS_CIN_LAST));
      u2 = 8'((3 << I_KW2) | (1 << I_IS_CIN_LAST));
      @(negedge aclk);
      cfg_valid = 1'b1; cfg_kw2 = 2'd1; cfg_cols_1 = '0; cfg_cin_1 = '0; cfg_blocks_1 = '0;
      m_ready = 1'b0; s_valid = 1'b0;
      @(negedge aclk);
      cfg_valid = 1'b0; s_valid = 1'b1; s_data = d1;
      #1;
      n_checks++;
      if (cfg_ready !== 1'b0 || m_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL b2b cfg_state: got cfg_ready=%b m_valid=%b want 0 0", cfg_ready, m_valid);
      end
      @(negedge aclk);
      m_ready = 1'b1;
      #1;
      n_checks++;
      if (m_valid !== 1'b1 || m_user !== cfg_beat_user(1) || m_data !== 64'd0) begin
         n_fail++;
         $display("FAIL b2b cfg_beat1: got v=%b u=%h d=%h want 1 %h 0", m_valid, m_user, m_data, cfg_beat_user(1));
      end
      @(negedge aclk);
      s_valid = 1'b0; m_ready = 1'b0;
      cfg_valid = 1'b1; cfg_kw2 = 2'd3;
      #1;
      n_checks++;
      if (m_valid !== 1'b1 || m_data !== d1 || m_user !== u1 || m_last !== 1'b1 || cfg_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL b2b last_pending: got v=%b d=%h u=%h l=%b cfg_ready=%b want 1 %h %h 1 1",
                  m_valid, m_data, m_user, m_last, cfg_ready, d1, u1);
      end
      @(negedge aclk);
      cfg_valid = 1'b0;
      #1;
      n_checks++;
      if (m_valid !== 1'b1 || m_data !== d1 || m_last !== 1'b1 || busy !== 1'b1 || cfg_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL b2b cfg_waits: got v=%b d=%h l=%b busy=%b cfg_ready=%b want 1 %h 1 1 0",
                  m_valid, m_data, m_last, busy, cfg_ready, d1);
      end
      @(negedge aclk);
      m_ready = 1'b1;
      @(negedge aclk);
      s_valid = 1'b1; s_data = d2;
      #1;
      n_checks++;
      if (m_valid !== 1'b1 || m_user !== cfg_beat_user(3) || m_data !== 64'd0) begin
         n_fail++;
         $display("FAIL b2b cfg_beat2: got v=%b u=%h d=%h want 1 %h 0", m_valid, m_user, m_data, cfg_beat_user(3));
      end
      @(negedge aclk);
      s_valid = 1'b0;
      #1;
      n_checks++;
      if (m_valid !== 1'b1 || m_data !== d2 || m_user !== u2 || m_last !== 1'b1) begin
         n_fail++;
         $display("FAIL b2b data2: got v=%b d=%h u=%h l=%b want 1 %h %h 1", m_valid, m_data, m_user, m_last, d2, u2);
      end
      @(negedge aclk);
      #1;
      n_checks++;
      if (m_valid !== 1'b0 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL b2b final_idle: got v=%b busy=%b want 0 0", m_valid, busy);
      end
      $display("back_to_back sequence done");
   endtask

   task automatic test_reset_mid_stream();
      int near, cyc;
      run_layer("pre_reset", 2, 7, 1, 0, 60, 90, 6, near, cyc);
      @(negedge aclk);
      areset = 1'b1; s_valid = 1'b0; cfg_valid = 1'b0;
      @(negedge aclk);
      areset = 1'b0;
      #1;
      n_checks++;
      if (m_valid !== 1'b0 || busy !== 1'b0 || cfg_ready !== 1'b1 || m_user !== 8'd0) begin
         n_fail++;
         $display("FAIL mid_reset state: got v=%b busy=%b cfg_ready=%b u=%h want 0 0 1 00",
                  m_valid, busy, cfg_ready, m_user);
      end
      run_layer("post_reset", 2, 7, 1, 0, 60, 90, -1, near, cyc);
      n_checks++;
      if (near != 2) begin
         n_fail++;
         $display("FAIL post_reset near_end_count: got %0d want 2", near);
      end
   endtask

   task automatic test_random_layers();
      int near, cyc, kw2, cols_1, cin_1, blocks_1, want_near;
      for (int i = 0; i < 4; i++) begin
         kw2 = $urandom_range(0, 3);
         cols_1 = $urandom_range(0, 5);
         cin_1 = $urandom_range(0, 2);
         blocks_1 = $urandom_range(0, 2);
         run_layer("random", kw2, cols_1, cin_1, blocks_1, 65, 75, -1, near, cyc);
         want_near = (kw2 != 0 && cols_1 >= kw2) ? (cin_1 + 1) * (blocks_1 + 1) : 0;
         n_checks++;
         if (near != want_near) begin
            n_fail++;
            $display("FAIL random near_end_count: got %0d want %0d (kw2=%0d cols_1=%0d)",
                     near, want_near, kw2, cols_1);
         end
      end
   endtask

   initial begin
      test_reset();
      test_basic_layer();
      test_backpressure();
      test_kw2_zero();
      test_single_beat();
      test_back_to_back();
      test_reset_mid_stream();
      test_random_layers();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
